// File: rtl/sw_step_ctrl_if.sv
// ----------------------------------------------------------------------------
// sw_step_ctrl_if
//
// Bundles the switch-conditioner signals between the raw switch pins, the
// conditioner and its consumer (the LED rotator).
//
//   iSW       [1:0] raw, asynchronous switch levels (bit0 = right, bit1 = left)
//   oSW       [1:0] one-cycle step command: 01 right, 10 left, 00 hold
//   oState    [1:0] current direction: 00 idle, 01 right, 10 left
//   oConflict       high while both debounced switches are on
//
// Modports:
//   master - the side that supplies the switch levels and observes the result
//   slave  - the conditioner itself
// ----------------------------------------------------------------------------
interface sw_step_ctrl_if;
  logic [1:0] iSW;
  logic [1:0] oSW;
  logic [1:0] oState;
  logic       oConflict;

  modport master (
    output iSW,
    input  oSW,
    input  oState,
    input  oConflict
  );

  modport slave (
    input  iSW,
    output oSW,
    output oState,
    output oConflict
  );
endinterface

// File: rtl/sw_step_ctrl.sv
// ----------------------------------------------------------------------------
// sw_step_ctrl
//
// Front-end conditioner for the two direction slide switches. The raw levels
// are synchronised (2 flops per bit), debounced independently per bit, decoded
// into a direction, and a held direction is turned into one-cycle step pulses
// spaced STEP_CYCLES apart. oSW feeds the LED rotator's step input directly.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles a synchronised bit must disagree with
//                    its debounced value before the new value is accepted (>=1)
//   STEP_CYCLES      cycles between step pulses while a direction is held (>=2)
//
// Ports:
//   iClk    system clock, rising edge
//   iRst_n  asynchronous active-low reset, clears every flop
//   bus     sw_step_ctrl_if.slave: iSW in; oSW, oState, oConflict out
//
// Timing (E0 = first edge that samples a new raw level):
//   debounced value changes at E(DEBOUNCE_CYCLES+1),
//   first step pulse is registered at E(DEBOUNCE_CYCLES+2).
// ----------------------------------------------------------------------------
module sw_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 12500000
) (
  input logic            iClk,
  input logic            iRst_n,
  sw_step_ctrl_if.slave  bus
);

  // A single-cycle debounce still needs a 1-bit counter to keep the
  // declarations legal; its value is then always 0.
  localparam int DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int StepW = $clog2(STEP_CYCLES);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);

  // Encodings equal the oState / oSW codes so both can be driven straight
  // from the state without a translation table.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN_R = 2'b01,
    RUN_L = 2'b10
  } state_e;

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [1:0] syncMeta;
  logic [1:0] syncQ;

  // NOTE: every flop sits on the async reset, including the synchroniser, so
  // a reset mid-run discards all progress and the debounce restarts from zero.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      syncMeta <= 2'b00;
      syncQ    <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make syncQ take the previous syncMeta,
      // which is what forms a two-stage chain rather than a single flop.
      syncMeta <= bus.iSW;
      syncQ    <= syncMeta;
    end
  end

  // --------------------------------------------------------------------------
  // Per-bit debounce: the counter only runs while the synchronised bit
  // disagrees with the accepted value, and any agreement resets it, so a
  // disagreement must be unbroken for DEBOUNCE_CYCLES cycles to be accepted.
  // --------------------------------------------------------------------------
  logic [1:0]     db;
  logic [DbW-1:0] dbCnt [2];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      db       <= 2'b00;
      dbCnt[0] <= '0;
      dbCnt[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (syncQ[b] == db[b]) begin
          dbCnt[b] <= '0;
        end else if (dbCnt[b] == DbLast) begin
          db[b]    <= syncQ[b];
          dbCnt[b] <= '0;
        end else begin
          dbCnt[b] <= dbCnt[b] + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decode: both switches on is illegal and treated as idle.
  // --------------------------------------------------------------------------
  state_e decoded;

  always_comb begin
    case (db)
      2'b01:   decoded = RUN_R;
      2'b10:   decoded = RUN_L;
      default: decoded = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Step FSM
  // --------------------------------------------------------------------------
  state_e           state;
  state_e           stateNext;
  logic [StepW-1:0] prescaler;
  logic [StepW-1:0] prescalerNext;
  logic [1:0]       swQ;
  logic [1:0]       swNext;
  logic             conflictQ;
  logic             conflictNext;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      swQ       <= 2'b00;
      conflictQ <= 1'b0;
    end else begin
      state     <= stateNext;
      prescaler <= prescalerNext;
      swQ       <= swNext;
      conflictQ <= conflictNext;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred; the branches below only override what changes.
    stateNext     = state;
    prescalerNext = '0;
    swNext        = 2'b00;
    conflictNext  = (db == 2'b11);

    if (decoded != state) begin
      // Any direction change, including a direct right<->left swap, emits
      // the new direction's step at once and restarts the period from it.
      // Leaving to IDLE emits nothing, so a release has no trailing pulse.
      stateNext = decoded;
      swNext    = decoded;
    end else if (state != IDLE) begin
      if (prescaler == StepLast) begin
        swNext = state;
      end else begin
        prescalerNext = prescaler + 1'b1;
      end
    end
  end

  assign bus.oSW       = swQ;
  assign bus.oState    = state;
  assign bus.oConflict = conflictQ;

endmodule

// File: tb/tb_sw_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sw_step_ctrl
//
// Directed bench for sw_step_ctrl with DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
// Inputs change 1 ns after a rising edge; the next rising edge is E0 for that
// change. Outputs are sampled 1 ns after each edge. With these parameters the
// debounced value changes at E5 and the first step is visible after E6.
//
// A vector drives iSW, advances 'edges' rising edges and then compares
// {oSW, oState, oConflict}; on every intermediate edge oSW must be 00.
// ----------------------------------------------------------------------------
module tb_sw_step_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 8;

  typedef struct {
    logic [1:0] sw;
    int         edges;
    logic [1:0] expSw;
    logic [1:0] expState;
    logic       expConf;
    string      name;
  } vec_t;

  logic iClk;
  logic iRst_n;

  sw_step_ctrl_if swIf ();

  sw_step_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .STEP_CYCLES     (STEP)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (swIf)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nTests = 0;
  int nFail  = 0;

  vec_t vecs[$];

  task automatic check(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got {oSW,oState,oConflict}=%b, expected %b",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic addVec(input logic [1:0] sw, input int edges,
                        input logic [1:0] expSw, input logic [1:0] expState,
                        input logic expConf, input string name);
    vec_t v;
    v.sw       = sw;
    v.edges    = edges;
    v.expSw    = expSw;
    v.expState = expState;
    v.expConf  = expConf;
    v.name     = name;
    vecs.push_back(v);
  endtask

  task automatic applyVec(input vec_t v);
    swIf.iSW = v.sw;
    for (int i = 0; i < v.edges; i++) begin
      tick();
      if (i < v.edges - 1)
        check({v.name, "_mid_osw"}, {swIf.oSW, 3'b000}, 5'b00000);
    end
    check(v.name, {swIf.oSW, swIf.oState, swIf.oConflict},
          {v.expSw, v.expState, v.expConf});
  endtask

  task automatic run(input logic [1:0] sw, input int edges,
                     input logic [1:0] expSw, input logic [1:0] expState,
                     input logic expConf, input string name);
    vec_t v;
    v.sw       = sw;
    v.edges    = edges;
    v.expSw    = expSw;
    v.expState = expState;
    v.expConf  = expConf;
    v.name     = name;
    applyVec(v);
  endtask

  initial begin
    // Table: hold right, release, short glitch, both-on conflict.
    addVec(2'b01, 6, 2'b00, 2'b00, 1'b0, "t2_e5_quiet");
    addVec(2'b01, 1, 2'b01, 2'b01, 1'b0, "t2_e6_pulse");
    addVec(2'b01, 1, 2'b00, 2'b01, 1'b0, "t2_e7_low");
    addVec(2'b01, 7, 2'b01, 2'b01, 1'b0, "t2_e14_pulse");
    addVec(2'b01, 1, 2'b00, 2'b01, 1'b0, "t2_e15_low");
    addVec(2'b01, 7, 2'b01, 2'b01, 1'b0, "t2_e22_pulse");
    addVec(2'b01, 1, 2'b00, 2'b01, 1'b0, "t2_e23_low");
    addVec(2'b00, 6, 2'b00, 2'b01, 1'b0, "rel_db_pending");
    addVec(2'b00, 1, 2'b00, 2'b00, 1'b0, "rel_idle");
    addVec(2'b01, 3, 2'b00, 2'b00, 1'b0, "t3_glitch");
    addVec(2'b00, 8, 2'b00, 2'b00, 1'b0, "t3_no_accept");
    addVec(2'b11, 6, 2'b00, 2'b00, 1'b0, "t5_e5_pending");
    addVec(2'b11, 1, 2'b00, 2'b00, 1'b1, "t5_conflict");
    addVec(2'b11, 10, 2'b00, 2'b00, 1'b1, "t5_conflict_hold");
    addVec(2'b00, 6, 2'b00, 2'b00, 1'b1, "t5_clear_pending");
    addVec(2'b00, 1, 2'b00, 2'b00, 1'b0, "t5_clear");

    // Test 1: reset asserted with a switch held.
    iRst_n   = 1'b1;
    swIf.iSW = 2'b01;
    #2 iRst_n = 1'b0;
    #1 check("t1_async_reset", {swIf.oSW, swIf.oState, swIf.oConflict}, 5'b0);
    for (int i = 0; i < 3; i++) tick();
    check("t1_reset_hold", {swIf.oSW, swIf.oState, swIf.oConflict}, 5'b0);
    iRst_n = 1'b1;
    run(2'b01, 6, 2'b00, 2'b00, 1'b0, "t1_latency");
    run(2'b01, 1, 2'b01, 2'b01, 1'b0, "t1_first_pulse");
    run(2'b00, 7, 2'b00, 2'b00, 1'b0, "t1_release_idle");

    foreach (vecs[i]) applyVec(vecs[i]);

    // Test 4: running right, then a direct swap to left on one edge.
    run(2'b01, 7, 2'b01, 2'b01, 1'b0, "t4_first_right");
    run(2'b01, 1, 2'b00, 2'b01, 1'b0, "t4_right_low");
    run(2'b10, 6, 2'b00, 2'b01, 1'b0, "t4_db_pending");
    run(2'b10, 1, 2'b10, 2'b10, 1'b0, "t4_left_pulse");
    run(2'b10, 8, 2'b10, 2'b10, 1'b0, "t4_left_repeat");
    run(2'b10, 3, 2'b00, 2'b10, 1'b0, "t4_mid_period");

    // Test 6: reset pulsed between edges while running left mid-period.
    @(negedge iClk);
    iRst_n = 1'b0;
    #1 check("t6_async_clear", {swIf.oSW, swIf.oState, swIf.oConflict}, 5'b0);
    tick();
    tick();
    check("t6_reset_hold", {swIf.oSW, swIf.oState, swIf.oConflict}, 5'b0);
    @(negedge iClk);
    iRst_n = 1'b1;
    run(2'b10, 6, 2'b00, 2'b00, 1'b0, "t6_relatch");
    run(2'b10, 1, 2'b10, 2'b10, 1'b0, "t6_first_pulse");
    run(2'b10, 1, 2'b00, 2'b10, 1'b0, "t6_after_pulse");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/sw_step_ctrl.md
Name: sw_step_ctrl

Overview:
Front-end conditioner for the board's two direction slide switches. It synchronises and debounces the raw switch levels and converts a held switch into periodic one-cycle step commands. Its oSW output drives the iSW input of the LED rotator directly, so the LED pattern advances one position per step period instead of once per clock. It also reports the current direction and flags the illegal both-on switch setting.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must differ from its debounced value before that value is accepted (20 ms at 50 MHz); must be >= 1.
STEP_CYCLES, 12500000, clock cycles between successive step pulses while a direction is held (0.25 s at 50 MHz); must be >= 2.
Counter widths are derived with $clog2 from these parameters.

Ports:
iClk  input  1  system clock; all logic is on the rising edge.
iRst_n  input  1  asynchronous, active-low reset.
iSW  input  2  raw, asynchronous switch levels: bit0 = rotate right, bit1 = rotate left.
oSW  output  2  registered step command: 01 = step right, 10 = step left, 00 = hold. Never 11.
oState  output  2  registered current direction: 00 = idle, 01 = right, 10 = left.
oConflict  output  1  registered flag, 1 while both debounced switches are on.

Behaviour:
- Reset (async assert, sync to nothing):
  - Every flop clears: synchroniser, debounce counters, debounced values, prescaler, state.
  - Outputs go to oSW=00, oState=00, oConflict=0 immediately on assertion.
- Synchroniser: 2-flop chain per bit, giving s[1:0].
- Debounce is per bit and independent, with debounced value db and counter cnt:
  - if s==db: cnt<=0;
  - else if cnt==DEBOUNCE_CYCLES-1: db<=s, cnt<=0;
  - else: cnt<=cnt+1.
  - A disagreement shorter than DEBOUNCE_CYCLES consecutive cycles never changes db.
- Decode of db:
  - 01 -> RIGHT, 10 -> LEFT, 00 -> IDLE.
  - 11 -> IDLE with oConflict<=1.
  - oConflict equals (db==11), registered one edge after db.
- FSM with states IDLE, RUN_R, RUN_L, mirrored on oState. Each edge:
  - If decode != state:
    - state<=decode, prescaler<=0.
    - oSW<=01 for RUN_R, 10 for RUN_L, 00 for IDLE.
    - Entering any RUN state therefore emits a step immediately.
    - This includes a direct RUN_R<->RUN_L change when both db bits flip on the same edge.
  - Else if state is RUN_x and prescaler==STEP_CYCLES-1: prescaler<=0, oSW<=direction code.
  - Else if state is RUN_x: prescaler<=prescaler+1, oSW<=00.
  - Else (IDLE): prescaler held at 0, oSW<=00.
- Pulse rules:
  - oSW is non-zero for exactly one cycle per step.
  - Steps are exactly STEP_CYCLES cycles apart while the direction is held.
  - A direction change restarts the period from the new pulse.
- Latency: E0 is the first rising edge that samples a new raw level.
  - db changes at edge E(DEBOUNCE_CYCLES+1).
  - The first oSW pulse is registered at edge E(DEBOUNCE_CYCLES+2).
- Release: when db returns to 00, state goes to IDLE on the next edge and oSW is 00 from that edge on. No trailing pulse.
- Reset mid-run: all progress is lost. After deassertion a still-held switch must pass the full debounce latency again before its first pulse.

Test Plan:
(Bench overrides DEBOUNCE_CYCLES=4, STEP_CYCLES=8.)
1. Assert iRst_n=0 with iSW=01 -> oSW=00, oState=00, oConflict=0, and they stay so until after release plus the debounce latency.
2. iSW=01 held from edge E0 -> oState=01 and oSW=01 after E6; oSW=01 again after E14 and E22, each for one cycle only; 00 in all other cycles.
3. iSW=01 for 3 cycles, then 00 -> oSW stays 00 and oState stays 00 throughout.
4. Running right, then iSW switched 01->10 on one edge -> oState goes 01->10 directly; a 10 pulse follows one edge after db changes, then repeats every 8 cycles; no 01 pulse after the change.
5. iSW=11 held -> oConflict=1 from E6, oState=00, oSW=00 throughout; iSW back to 00 -> oConflict=0 after debounce.
6. Running left mid-period, iRst_n pulsed low between clock edges -> oSW=00 and oState=00 asynchronously; after release with iSW=10 held, the first pulse arrives 6 edges later.
